// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared constants for the fetch/load-store memory port arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DERR  = 2'd3;

    localparam int STARVE_MAX_DEF = 3;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_starve_cnt
// Brief    : Saturating count of consecutive cycles a pending request is denied.
// Revision : 1.0
// ============================================================================
module mem_arb_starve_cnt #(
    parameter int MAX_COUNT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pending,
    input  logic granted,
    output logic at_max
);

    localparam int              CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT + 1) : 1;
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!pending || granted) begin
            r_cnt <= '0;
        end else if (r_cnt != C_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign at_max = (r_cnt == C_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and load/store.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              m_inst,
    output logic              m_read,
    output logic              m_write,
    output logic [1:0]        m_size,
    output logic              m_signed,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    logic              w_err;
    logic              w_starved;
    logic              w_d_mem;
    logic              w_d_bad;
    logic [1:0]        w_state_nxt;
    logic [1:0]        r_state;
    logic              r_d_rvalid;
    logic              r_d_err;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    always_comb begin
        w_err = 1'b0;
        case (d_size)
            SIZE_WORD: w_err = |d_addr[1:0];
            SIZE_HALF: w_err = d_addr[0];
            SIZE_BYTE: w_err = 1'b0;
            default:   w_err = 1'b1;
        endcase
    end

    // Rejected data requests never touch memory, so fetch can share their cycle.
    assign w_d_mem = ~rst & d_req & ~w_err & ~(if_req & w_starved);
    assign w_d_bad = ~rst & d_req & w_err;
    assign if_gnt  = ~rst & if_req & ~w_d_mem;
    assign d_gnt   = w_d_mem | w_d_bad;

    mem_arb_starve_cnt #(
        .MAX_COUNT (STARVE_MAX)
    ) u_starve_cnt (
        .clk     (sclk),
        .rst     (rst),
        .pending (if_req),
        .granted (if_gnt),
        .at_max  (w_starved)
    );

    always_comb begin
        m_inst   = 1'b0;
        m_read   = 1'b0;
        m_write  = 1'b0;
        m_size   = 2'b00;
        m_signed = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        if (if_gnt) begin
            m_inst = 1'b1;
            m_addr = if_addr;
        end else if (w_d_mem) begin
            m_read   = ~d_we;
            m_write  = d_we;
            m_size   = d_size;
            m_signed = d_signed;
            m_addr   = d_addr;
            m_wdata  = d_wdata;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (if_gnt)       w_state_nxt = ST_FETCH;
        else if (w_d_mem) w_state_nxt = ST_DATA;
        else if (w_d_bad) w_state_nxt = ST_DERR;
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_d_rvalid <= 1'b0;
            r_d_err    <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_d_rvalid <= d_gnt;
            r_d_err    <= w_d_bad;
            if (if_gnt) begin
                r_if_rdata <= m_rdata;
            end
            if (d_gnt) begin
                r_d_rdata <= (w_d_mem && !d_we) ? m_rdata : '0;
            end
        end
    end

    assign if_rvalid = (r_state == ST_FETCH);
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_err     = r_d_err;
    assign d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench with a behavioural memory model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic        sclk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_signed;
    logic [1:0]  d_size;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        m_inst, m_read, m_write, m_signed;
    logic [1:0]  m_size;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] imem [0:255];
    logic [7:0]  dmem [0:255];

    always #5 sclk = ~sclk;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(3)) dut (
        .sclk(sclk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_inst(m_inst), .m_read(m_read), .m_write(m_write), .m_size(m_size),
        .m_signed(m_signed), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Memory model: little-endian byte data array, word instruction array.
    always_comb begin
        m_rdata = '0;
        if (m_inst) begin
            m_rdata = imem[m_addr];
        end else if (m_read) begin
            case (m_size)
                2'b00: m_rdata = {dmem[m_addr + 8'd3], dmem[m_addr + 8'd2],
                                  dmem[m_addr + 8'd1], dmem[m_addr]};
                2'b01: m_rdata = {{16{m_signed & dmem[m_addr + 8'd1][7]}},
                                  dmem[m_addr + 8'd1], dmem[m_addr]};
                default: m_rdata = {{24{m_signed & dmem[m_addr][7]}}, dmem[m_addr]};
            endcase
        end
    end

    always @(posedge sclk) begin
        if (m_write) begin
            dmem[m_addr] <= m_wdata[7:0];
            if (m_size != 2'b10) dmem[m_addr + 8'd1] <= m_wdata[15:8];
            if (m_size == 2'b00) begin
                dmem[m_addr + 8'd2] <= m_wdata[23:16];
                dmem[m_addr + 8'd3] <= m_wdata[31:24];
            end
        end
    end

    // Advance to one time unit after the next rising edge (the drive/check point).
    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_size = 0; d_signed = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic set_data(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [7:0] a, input logic [31:0] wd);
        d_req = 1; d_we = we; d_size = sz; d_signed = sg; d_addr = a; d_wdata = wd;
    endtask

    task automatic test_reset();
        logic [114:0] outs;
        rst = 1;
        idle_inputs();
        if_req = 1; d_req = 1;
        #3;
        outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err, m_inst,
                m_read, m_write, m_size, m_signed, m_addr, m_wdata};
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        step();
        idle_inputs();
        rst = 0;
        step();
    endtask

    task automatic test_fetch_only();
        if_req = 1; if_addr = 8'd3;
        #1;
        total++;
        if ({if_gnt, d_gnt, m_inst, m_read, m_write, m_addr} !== {5'b10100, 8'd3}) begin
            bad++; $display("FAIL fetch_grant got=%b/%b inst=%b rd=%b wr=%b addr=%0d exp=1/0 1 0 0 3",
                            if_gnt, d_gnt, m_inst, m_read, m_write, m_addr);
        end
        step();
        if_req = 0;
        total++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h00000073}) begin
            bad++; $display("FAIL fetch_resp got=%b/%h exp=1/00000073", if_rvalid, if_rdata);
        end
        step();
        total++;
        if (if_rvalid !== 1'b0) begin
            bad++; $display("FAIL fetch_single_pulse got=%b exp=0", if_rvalid);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
        if_req = 1; if_addr = 8'd4;
        set_data(1'b0, 2'b00, 1'b0, 8'd0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if ({if_gnt, d_gnt} !== exp_g[i]) begin
                bad++; $display("FAIL contention_c%0d got if/d=%b exp=%b", i, {if_gnt, d_gnt}, exp_g[i]);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        set_data(1'b1, 2'b00, 1'b0, 8'd8, 32'hDEADBEEF);
        #1;
        total++;
        if ({d_gnt, m_write, m_read, m_addr, m_wdata} !== {3'b110, 8'd8, 32'hDEADBEEF}) begin
            bad++; $display("FAIL store_grant got=%b %b %b %0d %h exp=1 1 0 8 deadbeef",
                            d_gnt, m_write, m_read, m_addr, m_wdata);
        end
        step();
        total++;
        if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h0}) begin
            bad++; $display("FAIL store_resp got=%b/%b/%h exp=1/0/0", d_rvalid, d_err, d_rdata);
        end
        set_data(1'b0, 2'b00, 1'b0, 8'd8, 32'h0);
        #1;
        total++;
        if ({d_gnt, m_read, m_write} !== 3'b110) begin
            bad++; $display("FAIL load_grant got=%b%b%b exp=110", d_gnt, m_read, m_write);
        end
        step();
        idle_inputs();
        total++;
        if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            bad++; $display("FAIL load_resp got=%b/%b/%h exp=1/0/deadbeef", d_rvalid, d_err, d_rdata);
        end
        step();
    endtask

    task automatic test_misaligned();
        if_req = 1; if_addr = 8'd5;
        set_data(1'b0, 2'b00, 1'b0, 8'd6, 32'h0);
        #1;
        total++;
        if ({d_gnt, if_gnt, m_inst, m_read, m_write, m_addr} !== {5'b11100, 8'd5}) begin
            bad++; $display("FAIL misalign_grant got d=%b if=%b inst=%b rd=%b wr=%b addr=%0d exp=1 1 1 0 0 5",
                            d_gnt, if_gnt, m_inst, m_read, m_write, m_addr);
        end
        step();
        idle_inputs();
        total++;
        if ({d_rvalid, d_err, d_rdata, if_rvalid, if_rdata} !== {2'b11, 32'h0, 1'b1, 32'h12345678}) begin
            bad++; $display("FAIL misalign_resp got d=%b err=%b %h if=%b %h exp=1 1 0 1 12345678",
                            d_rvalid, d_err, d_rdata, if_rvalid, if_rdata);
        end
        set_data(1'b1, 2'b11, 1'b0, 8'd8, 32'h55);
        #1;
        total++;
        if ({d_gnt, if_gnt, m_inst, m_read, m_write, m_addr} !== {5'b10000, 8'd0}) begin
            bad++; $display("FAIL illegal_size_grant got d=%b if=%b inst=%b rd=%b wr=%b addr=%0d exp=1 0 0 0 0 0",
                            d_gnt, if_gnt, m_inst, m_read, m_write, m_addr);
        end
        step();
        idle_inputs();
        total++;
        if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL illegal_size_resp got=%b/%b/%h exp=1/1/0", d_rvalid, d_err, d_rdata);
        end
        step();
    endtask

    task automatic test_sign();
        set_data(1'b1, 2'b10, 1'b0, 8'd8, 32'h000000F1);
        step();
        set_data(1'b0, 2'b10, 1'b1, 8'd8, 32'h0);
        step();
        total++;
        if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'hFFFFFFF1}) begin
            bad++; $display("FAIL lb_signed got=%b/%b/%h exp=1/0/fffffff1", d_rvalid, d_err, d_rdata);
        end
        set_data(1'b0, 2'b10, 1'b0, 8'd8, 32'h0);
        step();
        idle_inputs();
        total++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h000000F1}) begin
            bad++; $display("FAIL lbu got=%b/%h exp=1/000000f1", d_rvalid, d_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        logic [1:0] exp_g [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
        logic [114:0] outs;
        if_req = 1; if_addr = 8'd3;
        set_data(1'b0, 2'b00, 1'b0, 8'd0, 32'h0);
        step();
        step();
        rst = 1;
        #1;
        outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err, m_inst,
                m_read, m_write, m_size, m_signed, m_addr, m_wdata};
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL reset_async got=%h exp=0", outs);
        end
        step();
        idle_inputs();
        rst = 0;
        step();
        total++;
        if ({if_rvalid, d_rvalid} !== 2'b00) begin
            bad++; $display("FAIL reset_no_rvalid got=%b%b exp=00", if_rvalid, d_rvalid);
        end
        if_req = 1; if_addr = 8'd3;
        set_data(1'b0, 2'b00, 1'b0, 8'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({if_gnt, d_gnt} !== exp_g[i]) begin
                bad++; $display("FAIL starve_restart_c%0d got if/d=%b exp=%b", i, {if_gnt, d_gnt}, exp_g[i]);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 8'h0;
        end
        imem[3] = 32'h00000073;
        imem[5] = 32'h12345678;
        test_reset();
        test_fetch_only();
        test_contention();
        test_back_to_back();
        test_misaligned();
        test_sign();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
